// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: computes the mult/div result up front, holds it pending
// for a fixed number of Busy cycles, then commits it to HI/LO.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        DUsesMD,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [63:0]   pend;
    logic          pend_we;

    logic        is_mul, is_div;
    logic [63:0] prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    assign is_mul = (MDOp == 3'd1) || (MDOp == 3'd2);
    assign is_div = (MDOp == 3'd3) || (MDOp == 3'd4);

    // Low 64 bits of a sign/zero-extended 64x64 product equal the 32x32 result.
    assign prod = {{32{(MDOp == 3'd1) & A[31]}}, A} * {{32{(MDOp == 3'd1) & B[31]}}, B};

    // Divide on magnitudes so the INT_MIN / -1 case never relies on signed overflow.
    assign a_neg = (MDOp == 3'd3) & A[31];
    assign b_neg = (MDOp == 3'd3) & B[31];
    assign a_mag = a_neg ? (~A + 32'd1) : A;
    assign b_mag = b_neg ? (~B + 32'd1) : B;
    assign q_mag = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
    assign r_mag = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
    assign quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

    assign Stall = DUsesMD & (Busy | (Start & (is_mul | is_div)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= '0;
            pend_we <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            Busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            3'd1, 3'd2: begin
                                pend    <= prod;
                                pend_we <= 1'b1;
                                cnt     <= CW'(MULT_CYCLES);
                                state   <= MULT;
                                Busy    <= 1'b1;
                            end
                            3'd3, 3'd4: begin
                                pend    <= {rem, quo};
                                pend_we <= (b_mag != 32'd0);
                                cnt     <= CW'(DIV_CYCLES);
                                state   <= DIV;
                                Busy    <= 1'b1;
                            end
                            3'd5:    HI <= A;
                            3'd6:    LO <= A;
                            default: ;
                        endcase
                    end
                end
                MULT, DIV: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        // Divide-by-zero still burns the cycles but leaves HI/LO alone.
                        if (pend_we) begin
                            HI <= pend[63:32];
                            LO <= pend[31:0];
                        end
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_md_scheduler.sv
// Table-driven bench for md_scheduler: one record per clock cycle, plus a
// hand-written Busy-length measurement at the end.
module tb_md_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        DUsesMD;
    logic        Busy, Stall;
    logic [31:0] HI, LO;

    int nvec = 0;
    int nerr = 0;

    md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .DUsesMD(DUsesMD), .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        du;
        logic        busy;
        logic        stall;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic rst, input logic start, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic du,
                     input logic busy, input logic stall,
                     input logic [31:0] hi, input logic [31:0] lo);
        vec_t t;
        t.rst = rst; t.start = start; t.op = op; t.a = a; t.b = b; t.du = du;
        t.busy = busy; t.stall = stall; t.hi = hi; t.lo = lo;
        tbl.push_back(t);
    endtask

    // n quiet cycles in which an operation is in flight
    task automatic busy_n(input int n, input logic [31:0] hi, input logic [31:0] lo);
        for (int i = 0; i < n; i++) v(0, 0, 3'd0, 0, 0, 0, 1, 0, hi, lo);
    endtask

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got busy/stall/hi/lo=%h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        // reset state
        v(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        // signed mult -2 * 3
        v(0, 1, 3'd1, 32'hFFFFFFFE, 32'd3, 0, 0, 0, 32'h0, 32'h0);
        busy_n(5, 32'h0, 32'h0);
        // commit visible; multu accepted in the first idle cycle after commit
        v(0, 1, 3'd2, 32'hFFFFFFFF, 32'd2, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        busy_n(5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        // signed div -7 / 2
        v(0, 1, 3'd3, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 32'h1, 32'hFFFFFFFE);
        busy_n(10, 32'h1, 32'hFFFFFFFE);
        // mthi, mtlo (no Busy), then divu by zero
        v(0, 1, 3'd5, 32'h11, 32'h0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        v(0, 1, 3'd6, 32'h22, 32'h0, 0, 0, 0, 32'h11, 32'hFFFFFFFD);
        v(0, 1, 3'd4, 32'h5, 32'h0, 0, 0, 0, 32'h11, 32'h22);
        busy_n(10, 32'h11, 32'h22);
        // reserved and none ops: no effect, no stall
        v(0, 1, 3'd7, 32'h99, 32'h0, 1, 0, 0, 32'h11, 32'h22);
        v(0, 1, 3'd0, 32'h98, 32'h0, 1, 0, 0, 32'h11, 32'h22);
        // hazard: mult 7*6 with DUsesMD held, ignored Starts while busy
        v(0, 1, 3'd1, 32'd7, 32'd6, 1, 0, 1, 32'h11, 32'h22);
        v(0, 1, 3'd5, 32'hDEAD, 32'h0, 1, 1, 1, 32'h11, 32'h22);
        v(0, 1, 3'd6, 32'hBEEF, 32'h0, 1, 1, 1, 32'h11, 32'h22);
        v(0, 1, 3'd3, 32'd9, 32'd3, 1, 1, 1, 32'h11, 32'h22);
        v(0, 1, 3'd1, 32'd2, 32'd2, 1, 1, 1, 32'h11, 32'h22);
        v(0, 1, 3'd4, 32'd8, 32'd0, 1, 1, 1, 32'h11, 32'h22);
        v(0, 1, 3'd6, 32'h55, 32'h0, 1, 0, 0, 32'h0, 32'h2A);
        // div aborted by reset in its third Busy cycle; reset beats a same-cycle mthi
        v(0, 1, 3'd4, 32'd100, 32'd7, 0, 0, 0, 32'h0, 32'h55);
        busy_n(2, 32'h0, 32'h55);
        v(1, 1, 3'd5, 32'h77, 32'h0, 0, 1, 0, 32'h0, 32'h55);
        v(0, 1, 3'd2, 32'd3, 32'd4, 0, 0, 0, 32'h0, 32'h0);
        busy_n(5, 32'h0, 32'h0);
        // signed div with negative divisor: 7 / -2
        v(0, 1, 3'd3, 32'd7, 32'hFFFFFFFE, 0, 0, 0, 32'h0, 32'hC);
        busy_n(10, 32'h0, 32'hC);
        v(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 32'h1, 32'hFFFFFFFD);

        reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = '0; B = '0; DUsesMD = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            reset = tbl[i].rst; Start = tbl[i].start; MDOp = tbl[i].op;
            A = tbl[i].a; B = tbl[i].b; DUsesMD = tbl[i].du;
            @(negedge clk);
            check($sformatf("vec%0d", i), {Busy, Stall, HI, LO},
                  {tbl[i].busy, tbl[i].stall, tbl[i].hi, tbl[i].lo});
        end

        // Measure Busy length of a signed mult -1 * -1 with a bounded wait.
        begin
            int cycles;
            @(posedge clk);
            #1;
            reset = 1'b0; Start = 1'b1; MDOp = 3'd1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
            DUsesMD = 1'b0;
            @(posedge clk);
            #1;
            Start = 1'b0; MDOp = 3'd0;
            cycles = 0;
            while (cycles < 50) begin
                @(negedge clk);
                if (!Busy) break;
                cycles++;
            end
            check("mult_busy_len", {34'd0, 32'(cycles)}, {34'd0, 32'd5});
            check("mult_neg1_sq", {Busy, Stall, HI, LO}, {1'b0, 1'b0, 32'h0, 32'h1});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/md_scheduler.md
MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 Parameter: MULT_CYCLES, default 5, number of Busy cycles for mult/multu.
REQ-002 Parameter: DIV_CYCLES, default 10, number of Busy cycles for div/divu.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: Start  input  1  E-stage strobe; an MD instruction is in E this cycle.
REQ-007 Port: MDOp  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-008 Port: A  input  32  E-stage forwarded rs value.
REQ-009 Port: B  input  32  E-stage forwarded rt value.
REQ-010 Port: DUsesMD  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
REQ-011 Port: Busy  output  1  multi-cycle operation in progress.
REQ-012 Port: Stall  output  1  stall request to the hazard unit (freeze PC/D, flush E).
REQ-013 Port: HI  output  32  architectural HI register.
REQ-014 Port: LO  output  32  architectural LO register.

Function
REQ-015 The block SHALL implement states IDLE, MULT and DIV plus a down-counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-016 In IDLE with Start=1 and MDOp in {1,2}: at the next edge, capture the 64-bit product into a pending register, load the counter with MULT_CYCLES, and enter MULT.
REQ-017 In IDLE with Start=1 and MDOp in {3,4}: at the next edge, capture quotient and remainder into the pending register, load the counter with DIV_CYCLES, and enter DIV.
REQ-018 mult: signed 32x32->64; multu: unsigned; HI = product[63:32], LO = product[31:0].
REQ-019 div: signed, quotient truncated toward zero, remainder takes the dividend's sign; divu: unsigned; LO = quotient, HI = remainder.
REQ-020 Divide by zero (B=0): the block SHALL still spend DIV_CYCLES Busy cycles, and HI/LO SHALL remain unchanged at completion.
REQ-021 Busy = 1 exactly while the state is MULT or DIV; Start at cycle t gives Busy=1 in cycles t+1 .. t+N (N = MULT_CYCLES or DIV_CYCLES).
REQ-022 The counter SHALL decrement each cycle in MULT/DIV; at the edge where it equals 1, commit the pending result to HI/LO and return to IDLE (new HI/LO visible in cycle t+N+1).
REQ-023 mthi (5) / mtlo (6) with Start=1 in IDLE: write A to HI / LO at the next edge, with no Busy cycle.
REQ-024 Start=1 while Busy=1 (any MDOp) SHALL be ignored: no state, counter, pending, HI or LO change.
REQ-025 Start=1 with MDOp 0 or 7 SHALL have no effect.
REQ-026 Stall = DUsesMD & (Busy | (Start & MDOp in {1,2,3,4})), combinational.
REQ-027 Stall SHALL be asserted in cycle t (Start of a mult/div) when DUsesMD=1, so that a dependent mfhi/mflo never reads stale HI/LO.
REQ-028 HI and LO SHALL change only at a commit (REQ-022), an mthi/mtlo write (REQ-023), or reset.
REQ-029 Commit and a new Start cannot coincide; Start in the first cycle with Busy=0 after a commit SHALL be accepted.

Reset
REQ-030 On reset=1 at a rising edge: state=IDLE, counter=0, pending=0, HI=0, LO=0, Busy=0.
REQ-031 Reset SHALL take priority over Start and over a commit in the same cycle.
REQ-032 Reset mid-operation SHALL abort the operation and discard the pending result; HI and LO SHALL read 0 afterward.
REQ-033 Stall SHALL follow only the current inputs and the reset state; with Busy=0 it depends solely on DUsesMD, Start and MDOp.

Verification
REQ-034 Signed mult: A=0xFFFFFFFE, B=3, Start at cycle 0 -> Busy=1 in cycles 1..5; HI=0xFFFFFFFF and LO=0xFFFFFFFA from cycle 6.
REQ-035 Multu: A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
REQ-036 Signed div: A=-7, B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
REQ-037 Divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo, then divu with B=0 -> 10 Busy cycles; HI=0x11 and LO=0x22 still.
REQ-038 Hazard: mult at cycle 0 with DUsesMD=1 held -> Stall=1 in cycles 0..5 and 0 in cycle 6; a second Start during cycles 1..5 changes nothing; mtlo in cycle 6 writes LO at the next edge.
REQ-039 Reset at cycle 3 of a div -> Busy=0, HI=0, LO=0 in cycle 4; a new mult started in cycle 4 completes normally.
